seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//   Receive end of the multiplexed 7-segment scan bus: watches the scanned
//   segment pattern / digit-position pair driven by the seven_segment scanner
//   and rebuilds the per-digit hex values.
//   Each position is latched only after it is stable, patterns are decoded to 4-bit hex, and
//   malformed position codes are flagged.
//   Used as an in-system readback/self-check of the display path.
// PARAMETERS
//   NUM_DIGITS     8   number of scan positions (width of data_pos)
//   STABLE_CYCLES  4   consecutive identical samples required before latching (>=1)
// PORTS
//   clk        in   1               system clock, rising edge
//   rst        in   1               asynchronous, active-low reset
//   data_out   in   7               scanned segment pattern {g,f,e,d,c,b,a}, active-high
//   data_pos   in   NUM_DIGITS      digit select, one-hot active-high, bit i = digit i
//   err_clr    in   1               clears pos_err (synchronous pulse)
//   digit_val  out  4*NUM_DIGITS    decoded hex per digit, digit i at [4i+3:4i]
//   digit_ok   out  NUM_DIGITS      1 = last latched pattern of digit i was a legal glyph
//   digit_wr   out  1               one-cycle pulse when any digit slot is written
//   frame_done out  1               one-cycle pulse when every digit latched since last frame
//   pos_err    out  1               sticky: data_pos seen with >1 bit set
// BEHAVIOUR
//   Reset (rst=0, async): digit_val=0, digit_ok=0, digit_wr=0, frame_done=0, pos_err=0,
//     seen mask=0, counter=0, FSM=IDLE, input regs=0. Effect is immediate mid-operation.
//   Input stage: data_out/data_pos registered once (seg_r,pos_r) every cycle.
//   FSM on registered inputs:
//     IDLE    : pos_r not one-hot -> stay; one-hot -> TRACK, cnt=1.
//     TRACK   : same {pos_r,seg_r} as last cycle -> cnt++; when cnt==STABLE_CYCLES
//               -> LATCH. Any change: new pos_r one-hot -> TRACK cnt=1, else IDLE.
//     LATCH   : one cycle: write slot, digit_wr=1, set seen[i] -> HOLD.
//     HOLD    : no rewrite while {pos_r,seg_r} unchanged; change -> as TRACK change rule.
//   Latency: value applied at pins from edge t, stable, is visible on digit_val after
//     edge t+STABLE_CYCLES+1; digit_wr high in that same cycle.
//   Decode (data_out {g..a} -> hex): 0111111=0 0000110=1 1011011=2 1001111=3
//     1100110=4 1101101=5 1111101=6 0000111=7 1111111=8 1101111=9 1110111=A
//     1111100=b 0111001=C 1011110=d 1111001=E 1110001=F. Any other (incl. blank
//     0000000): val=0, digit_ok[i]=0. Legal: digit_ok[i]=1.
//   Frame: when a LATCH makes seen all-ones, frame_done pulses in the next cycle and
//     seen clears to 0 in that same edge (the completing latch is not carried over).
//     Re-latching an already-seen digit does not advance the frame.
//   pos_err: set when pos_r has >=2 bits set (FSM goes/stays IDLE, nothing written);
//     cleared by err_clr; set and clear in the same cycle -> set wins.
//     pos_r==0 is blanking, not an error.
//   cnt saturates at STABLE_CYCLES; no wrap. Only one slot written per cycle.
// TESTING
//   1 Reset: rst=0 with random inputs -> all outputs 0; release, inputs idle -> stay 0.
//   2 Single digit: pos=8'h01, seg=7'b0000110 held 6 cycles -> digit_val[3:0]=1,
//     digit_ok[0]=1, digit_wr one pulse exactly 5 edges after apply (STABLE_CYCLES=4).
//   3 Glitch: pos=8'h02 seg=1011011 for 3 cycles then 1001111 held -> only one write,
//     digit_val[7:4]=3.
//   4 Full frame: scan 8 digits 0..7 each held 8 cycles -> digit_val=32'h76543210,
//     digit_ok=8'hFF, frame_done one pulse after 8th write; rescan -> second pulse.
//   5 Illegal: pos=8'h03 -> pos_err=1, no digit_wr; err_clr with pos=8'h03 still
//     present -> pos_err stays 1; pos=8'h04 then err_clr -> pos_err=0.
//   6 Blank/unknown glyph 0000000 on pos=8'h10 -> digit_val[19:16]=0, digit_ok[4]=0;
//     assert rst mid-TRACK -> no write, outputs 0 immediately.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Purpose: rebuild per-digit hex values from a multiplexed 7-segment scan bus (pattern + one-hot position).
// Latency: a pattern/position pair sampled stable is written STABLE_CYCLES+1 edges after it reaches the pins.
// Backpressure: none; the scan bus is observed passively, and unstable or malformed samples are simply not latched.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [6:0]              data_out_i,
  input  logic [NUM_DIGITS-1:0]   data_pos_i,
  input  logic                    err_clr_i,
  output logic [4*NUM_DIGITS-1:0] digit_val_o,
  output logic [NUM_DIGITS-1:0]   digit_ok_o,
  output logic                    digit_wr_o,
  output logic                    frame_done_o,
  output logic                    pos_err_o
);

  // Counter must be able to hold STABLE_CYCLES itself (saturation value).
  localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_LATCH = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  // Input sample registers and the previous sample used for the stability compare.
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] pos_q;
  logic [6:0]            prev_seg_q;
  logic [NUM_DIGITS-1:0] prev_pos_q;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cnt_inc;

  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   ok_q, ok_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;

  logic                    same;
  logic                    pos_onehot;
  logic                    pos_multi;
  logic                    restart;
  logic                    wr_en;
  logic [3:0]              dec_val;
  logic                    dec_ok;

  // Map a {g,f,e,d,c,b,a} pattern to its hex value; bit 4 flags a recognised glyph.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0111111: r = {1'b1, 4'h0};
      7'b0000110: r = {1'b1, 4'h1};
      7'b1011011: r = {1'b1, 4'h2};
      7'b1001111: r = {1'b1, 4'h3};
      7'b1100110: r = {1'b1, 4'h4};
      7'b1101101: r = {1'b1, 4'h5};
      7'b1111101: r = {1'b1, 4'h6};
      7'b0000111: r = {1'b1, 4'h7};
      7'b1111111: r = {1'b1, 4'h8};
      7'b1101111: r = {1'b1, 4'h9};
      7'b1110111: r = {1'b1, 4'hA};
      7'b1111100: r = {1'b1, 4'hB};
      7'b0111001: r = {1'b1, 4'hC};
      7'b1011110: r = {1'b1, 4'hD};
      7'b1111001: r = {1'b1, 4'hE};
      7'b1110001: r = {1'b1, 4'hF};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Register the scan bus once, and keep last cycle's sample for the stability compare.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_q      <= '0;
      pos_q      <= '0;
      prev_seg_q <= '0;
      prev_pos_q <= '0;
    end else begin
      seg_q      <= data_out_i;
      pos_q      <= data_pos_i;
      prev_seg_q <= seg_q;
      prev_pos_q <= pos_q;
    end
  end

  assign same       = (pos_q == prev_pos_q) && (seg_q == prev_seg_q);
  assign pos_onehot = $onehot(pos_q);
  assign pos_multi  = !$onehot0(pos_q);
  assign cnt_inc    = (cnt_q >= CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
  assign {dec_ok, dec_val} = decode(seg_q);

  // Next-state logic: count identical samples, latch once, then hold until the bus changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    restart = 1'b0;
    unique case (state_q)
      // IDLE uses the same entry rule as any change: one-hot starts tracking.
      S_IDLE: restart = 1'b1;
      S_TRACK: begin
        if (same) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) state_d = S_LATCH;
        end else begin
          restart = 1'b1;
        end
      end
      S_LATCH, S_HOLD: begin
        if (same) state_d = S_HOLD;
        else      restart = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // A new one-hot sample counts as the first stable one; anything else parks in IDLE.
    if (restart) begin
      if (pos_onehot) begin
        cnt_d   = CNT_ONE;
        state_d = (STABLE_CYCLES <= 1) ? S_LATCH : S_TRACK;
      end else begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    end
  end

  // The slot is written on the edge that enters LATCH, so the value and digit_wr appear together.
  assign wr_en = (state_d == S_LATCH);

  // Slot, frame and error bookkeeping.
  always_comb begin
    val_d   = val_q;
    ok_d    = ok_q;
    seen_d  = seen_q;
    // The cycle after a frame-completing write reports the frame and restarts the mask.
    frame_d = (state_q == S_LATCH) && (&seen_q);
    if (frame_d) seen_d = '0;
    if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (pos_q[i]) begin
          val_d[4*i +: 4] = dec_ok ? dec_val : 4'h0;
          ok_d[i]         = dec_ok;
          seen_d[i]       = 1'b1;
        end
      end
    end
    // A malformed position in the same cycle as a clear keeps the flag set.
    if (pos_multi)      err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      ok_q    <= '0;
      seen_q  <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      ok_q    <= ok_d;
      seen_q  <= seen_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign digit_val_o  = val_q;
  assign digit_ok_o   = ok_q;
  assign digit_wr_o   = (state_q == S_LATCH);
  assign frame_done_o = frame_q;
  assign pos_err_o    = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Purpose: directed self-checking bench for seg_scan_decoder (NUM_DIGITS=8, STABLE_CYCLES=4).
// Latency: checks the pins-to-digit_val delay of STABLE_CYCLES+1 edges.
// Backpressure: none; the bench drives the scan bus freely.
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  data_out;
  logic [7:0]  data_pos;
  logic        err_clr;
  logic [31:0] digit_val;
  logic [7:0]  digit_ok;
  logic        digit_wr;
  logic        frame_done;
  logic        pos_err;

  int checks = 0;
  int errors = 0;

  seg_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_out_i   (data_out),
    .data_pos_i   (data_pos),
    .err_clr_i    (err_clr),
    .digit_val_o  (digit_val),
    .digit_ok_o   (digit_ok),
    .digit_wr_o   (digit_wr),
    .frame_done_o (frame_done),
    .pos_err_o    (pos_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] glyph(input int v);
    logic [6:0] g;
    case (v)
      0: g = 7'b0111111;
      1: g = 7'b0000110;
      2: g = 7'b1011011;
      3: g = 7'b1001111;
      4: g = 7'b1100110;
      5: g = 7'b1101101;
      6: g = 7'b1111101;
      7: g = 7'b0000111;
      8: g = 7'b1111111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; data_out = '0; data_pos = '0; err_clr = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_out = 7'($urandom);
      data_pos = 8'($urandom);
      err_clr  = 1'($urandom);
      step(1);
    end
    checks++;
    if ({digit_val, digit_ok, digit_wr, frame_done, pos_err} !== 43'd0) begin
      errors++;
      $display("FAIL reset_hold: got val=%h ok=%h wr=%b fd=%b err=%b, expected all 0",
               digit_val, digit_ok, digit_wr, frame_done, pos_err);
    end
    data_out = '0; data_pos = '0; err_clr = 1'b0;
    rst_n = 1'b1;
    step(5);
    checks++;
    if ({digit_val, digit_ok, digit_wr, frame_done, pos_err} !== 43'd0) begin
      errors++;
      $display("FAIL reset_idle: got val=%h ok=%h wr=%b fd=%b err=%b, expected all 0",
               digit_val, digit_ok, digit_wr, frame_done, pos_err);
    end
  endtask

  task automatic test_single_digit();
    int wr_cnt = 0;
    int wr_at  = -1;
    data_pos = 8'h01;
    data_out = 7'b0000110;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (digit_wr) begin
        wr_cnt++;
        wr_at = k;
      end
      if (k == 4) begin
        checks++;
        if (digit_val[3:0] !== 4'h0) begin
          errors++;
          $display("FAIL single_early: digit_val[3:0]=%h before latency, expected 0", digit_val[3:0]);
        end
      end
    end
    checks++;
    if (wr_cnt !== 1) begin
      errors++;
      $display("FAIL single_wr_count: got %0d writes, expected 1", wr_cnt);
    end
    checks++;
    if (wr_at !== 5) begin
      errors++;
      $display("FAIL single_wr_edge: write seen %0d edges after apply, expected 5", wr_at);
    end
    checks++;
    if (digit_val[3:0] !== 4'h1 || digit_ok[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_value: got val=%h ok=%b, expected val=1 ok=1", digit_val[3:0], digit_ok[0]);
    end
  endtask

  task automatic test_glitch();
    int wr_cnt = 0;
    data_pos = 8'h02;
    data_out = 7'b1011011;
    for (int k = 0; k < 3; k++) begin
      step(1);
      if (digit_wr) wr_cnt++;
    end
    data_out = 7'b1001111;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (digit_wr) wr_cnt++;
    end
    checks++;
    if (wr_cnt !== 1) begin
      errors++;
      $display("FAIL glitch_wr_count: got %0d writes, expected 1", wr_cnt);
    end
    checks++;
    if (digit_val[7:0] !== 8'h31 || digit_ok[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL glitch_value: got val=%h ok=%b, expected val=31 ok=11", digit_val[7:0], digit_ok[1:0]);
    end
  endtask

  task automatic test_full_frame();
    int cyc = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    int last_wr = -1;
    int fd_at = -1;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int d = 0; d < 8; d++) begin
        data_pos = 8'(1 << d);
        data_out = glyph(d);
        for (int k = 0; k < 8; k++) begin
          step(1);
          cyc++;
          if (digit_wr) begin
            wr_cnt++;
            last_wr = cyc;
          end
          if (frame_done) begin
            fd_cnt++;
            fd_at = cyc;
          end
        end
      end
      if (pass == 0) begin
        checks++;
        if (fd_cnt !== 1 || fd_at !== last_wr + 1) begin
          errors++;
          $display("FAIL frame_first: got %0d pulses at cycle %0d, expected 1 pulse at cycle %0d",
                   fd_cnt, fd_at, last_wr + 1);
        end
        checks++;
        if (digit_val !== 32'h76543210 || digit_ok !== 8'hFF) begin
          errors++;
          $display("FAIL frame_values: got val=%h ok=%h, expected val=76543210 ok=ff", digit_val, digit_ok);
        end
      end
    end
    checks++;
    if (wr_cnt !== 16) begin
      errors++;
      $display("FAIL frame_wr_count: got %0d writes, expected 16", wr_cnt);
    end
    checks++;
    if (fd_cnt !== 2 || fd_at !== last_wr + 1) begin
      errors++;
      $display("FAIL frame_second: got %0d pulses, last at %0d, expected 2 pulses, last at %0d",
               fd_cnt, fd_at, last_wr + 1);
    end
  endtask

  task automatic test_illegal_pos();
    int wr_cnt = 0;
    data_pos = 8'h03;
    data_out = glyph(5);
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (digit_wr) wr_cnt++;
    end
    checks++;
    if (pos_err !== 1'b1 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL illegal_set: got pos_err=%b writes=%0d, expected pos_err=1 writes=0", pos_err, wr_cnt);
    end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    checks++;
    if (pos_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_set_wins: got pos_err=%b, expected 1", pos_err);
    end
    data_pos = 8'h04;
    step(2);
    checks++;
    if (pos_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: got pos_err=%b, expected 1", pos_err);
    end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    checks++;
    if (pos_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: got pos_err=%b, expected 0", pos_err);
    end
  endtask

  task automatic test_blank_and_reset();
    int wr_cnt = 0;
    data_pos = 8'h10;
    data_out = glyph(8);
    step(8);
    checks++;
    if (digit_val[19:16] !== 4'h8 || digit_ok[4] !== 1'b1) begin
      errors++;
      $display("FAIL blank_pre: got val=%h ok=%b, expected val=8 ok=1", digit_val[19:16], digit_ok[4]);
    end
    data_out = 7'b0000000;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (digit_wr) wr_cnt++;
    end
    checks++;
    if (digit_val[19:16] !== 4'h0 || digit_ok[4] !== 1'b0 || wr_cnt !== 1) begin
      errors++;
      $display("FAIL blank_glyph: got val=%h ok=%b writes=%0d, expected val=0 ok=0 writes=1",
               digit_val[19:16], digit_ok[4], wr_cnt);
    end
    data_pos = 8'h20;
    data_out = glyph(6);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({digit_val, digit_ok, digit_wr, frame_done, pos_err} !== 43'd0) begin
      errors++;
      $display("FAIL reset_async: got val=%h ok=%h wr=%b fd=%b err=%b, expected all 0",
               digit_val, digit_ok, digit_wr, frame_done, pos_err);
    end
    wr_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      if (digit_wr) wr_cnt++;
    end
    data_pos = '0;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (digit_wr) wr_cnt++;
    end
    checks++;
    if (wr_cnt !== 0 || digit_val !== 32'h0 || digit_ok !== 8'h00) begin
      errors++;
      $display("FAIL reset_midtrack: got writes=%0d val=%h ok=%h, expected 0 writes, val=0 ok=0",
               wr_cnt, digit_val, digit_ok);
    end
  endtask

  initial begin
    rst_n = 1'b0; data_out = '0; data_pos = '0; err_clr = 1'b0;
    test_reset();
    test_single_digit();
    test_glitch();
    test_full_frame();
    test_illegal_pos();
    test_blank_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
